// File: rtl/vuprs_adc_sample_sched.sv
// vuprs_adc_sample_sched: shared conversion-trigger scheduler for NUM_ADC AD7606
// controllers. Generates a periodic or software-initiated trigger, waits for every
// controller to finish sampling (with a timeout) and keeps frame/overrun/timeout counts.
module vuprs_adc_sample_sched #(
  parameter int unsigned NUM_ADC    = 2,
  parameter int unsigned DIV_WIDTH  = 24,
  parameter int unsigned MIN_PERIOD = 100,
  parameter int unsigned TRIG_HIGH  = 4,
  parameter int unsigned TIMEOUT    = 2500,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic                 cfg_sw_mode,
  input  logic [DIV_WIDTH-1:0] cfg_period,
  input  logic                 sw_trigger,
  input  logic [NUM_ADC-1:0]   adc_reset_down,
  input  logic [NUM_ADC-1:0]   adc_sampling,
  input  logic [NUM_ADC-1:0]   adc_error,
  output logic                 trigger,
  output logic                 frame_valid,
  output logic                 frame_error,
  output logic [NUM_ADC-1:0]   frame_err_mask,
  output logic [CNT_WIDTH-1:0] frame_index,
  output logic [CNT_WIDTH-1:0] overrun_count,
  output logic [CNT_WIDTH-1:0] timeout_count,
  output logic                 active
);

  localparam int unsigned HW = (TRIG_HIGH > 1) ? $clog2(TRIG_HIGH) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [HW-1:0]        H_LAST = HW'(TRIG_HIGH - 1);
  localparam logic [HW-1:0]        H_ONE  = HW'(1);
  localparam logic [TW-1:0]        T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]        T_ONE  = TW'(1);
  localparam logic [DIV_WIDTH-1:0] P_MIN  = DIV_WIDTH'(MIN_PERIOD);
  localparam logic [DIV_WIDTH-1:0] P_ONE  = DIV_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_TRIG,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_n;
  logic [DIV_WIDTH-1:0] per_cnt;
  logic [DIV_WIDTH-1:0] per_len;
  logic [DIV_WIDTH-1:0] per_clamp;
  logic                 tick;
  logic                 sw_q;
  logic                 sw_edge;
  logic [HW-1:0]        hcnt;
  logic [TW-1:0]        tcnt;
  logic [NUM_ADC-1:0]   seen_q;
  logic                 rd_ok;
  logic                 complete;
  logic                 overrun_hit;
  logic                 timeout_hit;

  // Derived conditions: clamped period, period tick, sw edge, readiness and frame completion.
  always_comb begin
    per_clamp = (cfg_period < P_MIN) ? P_MIN : cfg_period;
    tick      = (state_q != S_IDLE) && !cfg_sw_mode && (per_cnt == per_len - P_ONE);
    sw_edge   = sw_trigger & ~sw_q;
    rd_ok     = &adc_reset_down;
    complete  = (&seen_q) && (adc_sampling == '0);
  end

  // Period counter; the period length is re-latched only while idle and at each wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt <= '0;
      per_len <= P_MIN;
    end else if (state_q == S_IDLE || cfg_sw_mode) begin
      per_cnt <= '0;
      per_len <= per_clamp;
    end else if (tick) begin
      per_cnt <= '0;
      per_len <= per_clamp;
    end else begin
      per_cnt <= per_cnt + P_ONE;
    end
  end

  // Frame bookkeeping: sw edge register, trigger-high counter, timeout counter, seen mask.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_q   <= 1'b0;
      hcnt   <= '0;
      tcnt   <= '0;
      seen_q <= '0;
    end else begin
      sw_q <= sw_trigger;
      hcnt <= (state_q == S_TRIG) ? hcnt + H_ONE : '0;
      tcnt <= (state_q == S_TRIG || state_q == S_WAIT) ? tcnt + T_ONE : '0;
      if (state_q == S_TRIG) begin
        seen_q <= '0;
      end else if (state_q == S_WAIT) begin
        seen_q <= seen_q | adc_sampling;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic plus overrun/timeout event strobes.
  // A frame that ends while disabled goes straight to IDLE instead of passing through ARMED.
  always_comb begin
    state_n     = state_q;
    overrun_hit = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_enable && rd_ok) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (!rd_ok || !cfg_enable) begin
          state_n = S_IDLE;
        end else if (tick || (cfg_sw_mode && sw_edge)) begin
          state_n = S_TRIG;
        end
      end
      S_TRIG: begin
        if (!rd_ok) begin
          state_n = S_IDLE;
        end else begin
          overrun_hit = tick;
          if (hcnt == H_LAST) state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!rd_ok) begin
          state_n = S_IDLE;
        end else begin
          overrun_hit = tick;
          if (complete) begin
            state_n = S_DONE;
          end else if (tcnt == T_LAST) begin
            timeout_hit = 1'b1;
            state_n     = cfg_enable ? S_ARMED : S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (!rd_ok) begin
          state_n = S_IDLE;
        end else begin
          overrun_hit = tick;
          state_n     = cfg_enable ? S_ARMED : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Registered outputs and statistics, all decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trigger        <= 1'b0;
      frame_valid    <= 1'b0;
      frame_error    <= 1'b0;
      frame_err_mask <= '0;
      frame_index    <= '0;
      overrun_count  <= '0;
      timeout_count  <= '0;
      active         <= 1'b0;
    end else begin
      trigger     <= (state_n == S_TRIG);
      frame_valid <= (state_n == S_DONE);
      frame_error <= timeout_hit;
      active      <= (state_n != S_IDLE);
      if (state_n == S_DONE) begin
        frame_err_mask <= adc_error;
        frame_index    <= frame_index + C_ONE;
      end
      if (overrun_hit && !(&overrun_count)) overrun_count <= overrun_count + C_ONE;
      if (timeout_hit && !(&timeout_count)) timeout_count <= timeout_count + C_ONE;
    end
  end

endmodule

// File: tb/tb_vuprs_adc_sample_sched.sv
// Testbench for vuprs_adc_sample_sched: an event-timeline reference model fills a
// scoreboard, emulated controllers answer the trigger, and a monitor checks DUT pulses.
module tb_vuprs_adc_sample_sched;

  localparam int unsigned N    = 2;
  localparam int unsigned DW   = 24;
  localparam int          MINP = 100;
  localparam int          TH   = 4;
  localparam int          TO   = 2500;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic          cfg_sw_mode;
  logic [DW-1:0] cfg_period;
  logic          sw_trigger;
  logic [N-1:0]  adc_reset_down;
  logic [N-1:0]  adc_sampling;
  logic [N-1:0]  adc_error;
  logic          trigger;
  logic          frame_valid;
  logic          frame_error;
  logic [N-1:0]  frame_err_mask;
  logic [CW-1:0] frame_index;
  logic [CW-1:0] overrun_count;
  logic [CW-1:0] timeout_count;
  logic          active;

  vuprs_adc_sample_sched #(
    .NUM_ADC(N), .DIV_WIDTH(DW), .MIN_PERIOD(MINP),
    .TRIG_HIGH(TH), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_sw_mode(cfg_sw_mode),
    .cfg_period(cfg_period), .sw_trigger(sw_trigger), .adc_reset_down(adc_reset_down),
    .adc_sampling(adc_sampling), .adc_error(adc_error), .trigger(trigger),
    .frame_valid(frame_valid), .frame_error(frame_error), .frame_err_mask(frame_err_mask),
    .frame_index(frame_index), .overrun_count(overrun_count),
    .timeout_count(timeout_count), .active(active)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 trigger rise (a=overrun, b=timeout), 1 frame_valid (a=index, b=mask), 2 frame_error (a=timeout)
  typedef struct {int kind; int cyc; int a; int b;} ev_t;
  // per-frame controller behaviour: response delay, busy length per ADC (0 = never), error flags
  typedef struct {int d; int b0; int b1; int err;} fr_t;

  ev_t sbq[$];
  fr_t frames[$];
  fr_t plan[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en = 1'b1;
  int  exp_idx = 0;
  int  exp_ovr = 0;
  int  exp_tmo = 0;
  int  last_ev = 0;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int a, input int b);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b;
    sbq.push_back(e);
    if (c > last_ev) last_ev = c;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected outcome of one frame whose trigger rises at cycle t; returns the last busy cycle.
  task automatic model_frame(input int t, input fr_t f, output int endc);
    int mb, c;
    push(0, t, exp_ovr, exp_tmo);
    mb = (f.b0 > f.b1) ? f.b0 : f.b1;
    c  = t + f.d + mb;
    if (f.b0 > 0 && f.b1 > 0 && c <= t + TO - 1) begin
      exp_idx = (exp_idx + 1) % 65536;
      push(1, c + 1, exp_idx, f.err);
      endc = c + 1;
    end else begin
      if (exp_tmo < 65535) exp_tmo++;
      push(2, t + TO, exp_tmo, 0);
      endc = t + TO - 1;
    end
    frames.push_back(f);
  endtask

  // Periodic run over the frames in plan; ends by dropping enable in ARMED or mid-WAIT.
  task automatic run_periodic(input int cfgp, input bit drop_mid);
    int p, e0, x, t, endc, y, drop_at;
    fr_t f;
    p = (cfgp < MINP) ? MINP : cfgp;
    t = 0;
    endc = 0;
    @(negedge clk);
    cfg_period     = DW'(cfgp);
    cfg_sw_mode    = 1'b0;
    adc_reset_down = '1;
    cfg_enable     = 1'b1;
    e0 = cyc + 1;
    x  = e0 + p;
    while (plan.size() > 0) begin
      f = plan.pop_front();
      t = x;
      model_frame(t, f, endc);
      y = t + p;
      while (y - 1 <= endc) begin
        if (exp_ovr < 65535) exp_ovr++;
        y += p;
      end
      x = y;
    end
    drop_at = drop_mid ? t + 50 : endc + 1;
    wait_until(drop_at);
    cfg_enable = 1'b0;
    wait_until(last_ev + 3);
    chk("queue_drained", sbq.size(), 0);
    chk("active_after_disable", active, 0);
    chk("overrun_total", overrun_count, exp_ovr);
    chk("timeout_total", timeout_count, exp_tmo);
  endtask

  task automatic pulse_sw(input int s);
    wait_until(s);
    sw_trigger = 1'b1;
    wait_until(s + 3);
    sw_trigger = 1'b0;
  endtask

  // Software mode: three pulses, the second one lands while the first frame is in WAIT.
  task automatic run_sw();
    int e0, s1, s2, s3, t1, t2, endc1, endc2;
    fr_t f;
    @(negedge clk);
    cfg_sw_mode    = 1'b1;
    cfg_period     = DW'(150);
    adc_reset_down = '1;
    cfg_enable     = 1'b1;
    e0 = cyc + 1;
    f.d = 10; f.b0 = 200; f.b1 = 200; f.err = int'($urandom_range(0, 3));
    s1 = e0 + 20;
    t1 = s1 + 1;
    model_frame(t1, f, endc1);
    s2 = t1 + 50;
    s3 = endc1 + 30;
    t2 = s3 + 1;
    f.err = int'($urandom_range(0, 3));
    model_frame(t2, f, endc2);
    pulse_sw(s1);
    pulse_sw(s2);
    pulse_sw(s3);
    wait_until(endc2 + 1);
    cfg_enable = 1'b0;
    wait_until(last_ev + 3);
    chk("sw_queue_drained", sbq.size(), 0);
    chk("sw_overrun", overrun_count, exp_ovr);
    chk("sw_active_after_disable", active, 0);
    cfg_sw_mode = 1'b0;
  endtask

  task automatic ev(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      case (kind)
        0: begin
          chk("overrun_at_trigger", a, e.a);
          chk("timeout_at_trigger", b, e.b);
        end
        1: begin
          chk("frame_index", a, e.a);
          chk("frame_err_mask", b, e.b);
        end
        default: chk("timeout_count", a, e.a);
      endcase
    end
  endtask

  // Emulated controllers: respond to each trigger rise with that frame's busy windows.
  initial begin
    int  fi;
    int  t;
    bit  tp;
    fr_t f;
    fi = -1; t = 0; tp = 1'b0;
    f.d = 0; f.b0 = 0; f.b1 = 0; f.err = 0;
    adc_sampling = '0;
    adc_error    = '0;
    forever begin
      @(negedge clk);
      if (trigger === 1'b1 && !tp) begin
        fi++;
        t = cyc;
        if (fi < frames.size()) begin
          f = frames[fi];
        end else begin
          f.d = 0; f.b0 = 0; f.b1 = 0; f.err = 0;
        end
        adc_error = N'(f.err);
      end
      tp = (trigger === 1'b1);
      adc_sampling[0] = (cyc >= t + f.d) && (cyc < t + f.d + f.b0);
      adc_sampling[1] = (cyc >= t + f.d) && (cyc < t + f.d + f.b1);
    end
  end

  // Monitor: pops the scoreboard on every trigger rise / frame pulse; checks trigger width.
  initial begin
    bit tp;
    int hw;
    tp = 1'b0;
    hw = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (trigger === 1'b1 && !tp) ev(0, 32'(overrun_count), 32'(timeout_count));
        if (frame_valid === 1'b1) ev(1, 32'(frame_index), 32'(frame_err_mask));
        if (frame_error === 1'b1) ev(2, 32'(timeout_count), 0);
        if (trigger === 1'b1) begin
          hw++;
        end else if (tp) begin
          chk("trigger_width", hw, TH);
          hw = 0;
        end
        tp = (trigger === 1'b1);
      end
    end
  end

  initial begin
    #(4_000_000);
    n_err++;
    $display("FAIL watchdog: run did not complete by cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int  cp, d, b0, b1;
    fr_t f;
    rst = 1'b0;
    cfg_enable = 1'b0;
    cfg_sw_mode = 1'b0;
    cfg_period = '0;
    sw_trigger = 1'b0;
    adc_reset_down = '0;
    repeat (3) @(negedge clk);
    chk("rst_trigger", trigger, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_err_mask", frame_err_mask, 0);
    chk("rst_frame_index", frame_index, 0);
    chk("rst_overrun", overrun_count, 0);
    chk("rst_timeout", timeout_count, 0);
    chk("rst_active", active, 0);
    rst = 1'b1;

    // One controller still in reset: nothing may happen until it is released.
    @(negedge clk);
    adc_reset_down = N'(1);
    cfg_period = DW'(500);
    cfg_enable = 1'b1;
    repeat (600) @(negedge clk);
    chk("gated_active", active, 0);
    chk("gated_trigger", trigger, 0);
    for (int k = 0; k < 3; k++) begin
      f.d = 10; f.b0 = 200; f.b1 = 200; f.err = int'($urandom_range(0, 3));
      plan.push_back(f);
    end
    run_periodic(500, 1'b0);

    // Period below the minimum is clamped.
    for (int k = 0; k < 3; k++) begin
      f.d = int'($urandom_range(4, 20)); f.b0 = int'($urandom_range(1, 70));
      f.b1 = int'($urandom_range(1, 70)); f.err = int'($urandom_range(0, 3));
      plan.push_back(f);
    end
    run_periodic(20, 1'b0);

    // Busy longer than the period: every second tick is dropped.
    for (int k = 0; k < 3; k++) begin
      f.d = 10; f.b0 = 800; f.b1 = 800; f.err = int'($urandom_range(0, 3));
      plan.push_back(f);
    end
    run_periodic(500, 1'b0);

    // Timeout, recovery, and the completion/timeout boundary on both sides.
    f.d = 10; f.b0 = 200; f.b1 = 0;      f.err = 1; plan.push_back(f);
    f.d = 10; f.b0 = 200; f.b1 = 200;    f.err = 2; plan.push_back(f);
    f.d = 10; f.b0 = TO - 11; f.b1 = TO - 11; f.err = 3; plan.push_back(f);
    f.d = 10; f.b0 = TO - 10; f.b1 = 5;  f.err = 0; plan.push_back(f);
    run_periodic(500, 1'b0);

    // Randomised periodic runs.
    for (int s = 0; s < 3; s++) begin
      cp = int'($urandom_range(20, 800));
      for (int k = 0; k < 4; k++) begin
        d  = int'($urandom_range(4, 40));
        b0 = int'($urandom_range(1, 1200));
        b1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 1200));
        f.d = d; f.b0 = b0; f.b1 = b1; f.err = int'($urandom_range(0, 3));
        plan.push_back(f);
      end
      run_periodic(cp, 1'b0);
    end

    run_sw();

    // Enable dropped mid-WAIT: the frame still completes, then the block idles.
    f.d = 10; f.b0 = 200; f.b1 = 200; f.err = 1;
    plan.push_back(f);
    run_periodic(300, 1'b1);

    // Asynchronous reset while the trigger is high.
    mon_en = 1'b0;
    f.d = 10; f.b0 = 200; f.b1 = 200; f.err = 0;
    frames.push_back(f);
    @(negedge clk);
    cfg_period = DW'(100);
    cfg_enable = 1'b1;
    for (int k = 0; k < 300 && trigger !== 1'b1; k++) @(negedge clk);
    chk("trigger_before_reset", trigger, 1);
    #2 rst = 1'b0;
    #1;
    chk("areset_trigger", trigger, 0);
    chk("areset_active", active, 0);
    chk("areset_frame_index", frame_index, 0);
    chk("areset_overrun", overrun_count, 0);
    chk("areset_timeout", timeout_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vuprs_adc_sample_sched.md
Name: vuprs_adc_sample_sched

Overview:
Parametrised sample scheduler for NUM_ADC AD7606 controllers sharing one conversion trigger. It replaces the fixed toggle-divider trigger with the following features:
- runtime-programmable period, or a software-triggered mode;
- readiness gating on controller reset completion;
- per-frame completion tracking across all controllers, with a timeout;
- overrun and timeout statistics.
It sits between the system configuration logic and the ad7606 controller instances.

Parameters:
NUM_ADC, 2, number of controllers driven by the shared trigger
DIV_WIDTH, 24, width of period register
MIN_PERIOD, 100, smallest legal period in clk cycles; smaller cfg_period values are clamped to this
TRIG_HIGH, 4, trigger high time in clk cycles
TIMEOUT, 2500, cycles from trigger rise to frame completion before declaring timeout
CNT_WIDTH, 16, width of statistics and frame counters

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-low reset
cfg_enable  input  1  scheduler enable
cfg_sw_mode  input  1  0 = periodic triggering, 1 = software triggering
cfg_period  input  DIV_WIDTH  sample period in clk cycles
sw_trigger  input  1  software trigger, rising-edge detected
adc_reset_down  input  NUM_ADC  per-controller reset-complete flags
adc_sampling  input  NUM_ADC  per-controller busy-sampling flags
adc_error  input  NUM_ADC  per-controller error flags
trigger  output  1  shared usr_trigger to all controllers
frame_valid  output  1  one-cycle pulse: all controllers finished
frame_error  output  1  one-cycle pulse: frame timed out
frame_err_mask  output  NUM_ADC  adc_error sampled at frame end
frame_index  output  CNT_WIDTH  completed-frame counter
overrun_count  output  CNT_WIDTH  dropped periodic ticks, saturating
timeout_count  output  CNT_WIDTH  timed-out frames, saturating
active  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs are 0. The state machine is in IDLE and all counters are 0.
- States: IDLE, ARMED, TRIG, WAIT, DONE.
- IDLE -> ARMED: cfg_enable = 1 and adc_reset_down all-ones. The period counter clears on entry to ARMED.
- Period counter (periodic mode only):
  - runs while the state is not IDLE;
  - the effective period P = max(cfg_period, MIN_PERIOD);
  - a tick is issued when the counter reaches P-1; the counter wraps to 0 on that cycle;
  - cfg_period changes take effect at the next wrap.
- Tick handling:
  - tick in ARMED -> TRIG;
  - tick in TRIG, WAIT or DONE -> the tick is dropped and overrun_count increments, saturating at all-ones.
- Software mode:
  - a sw_trigger rising edge (one register stage of edge detection) in ARMED -> TRIG;
  - an edge in any other state is ignored and not counted;
  - the period counter is held at 0.
- TRIG:
  - trigger = 1 for exactly TRIG_HIGH cycles, registered output;
  - the timeout counter starts at the first trigger-high cycle;
  - the seen mask is cleared;
  - then -> WAIT.
- WAIT:
  - seen mask |= adc_sampling, sticky;
  - when seen mask is all-ones and adc_sampling is all-zeros -> DONE;
  - if the timeout counter reaches TIMEOUT first: frame_error pulses, timeout_count increments (saturating), then -> ARMED;
  - if completion and timeout occur in the same cycle, completion wins.
- DONE (one cycle):
  - frame_valid = 1;
  - frame_err_mask <= adc_error;
  - frame_index increments, wrapping at 2^CNT_WIDTH;
  - then -> ARMED.
- cfg_enable deasserted:
  - in ARMED -> IDLE next cycle;
  - in TRIG or WAIT, the current frame completes or times out first, then -> IDLE;
  - frame_index and the statistics counters hold their values.
- Any adc_reset_down bit falling in a non-IDLE state -> IDLE immediately, trigger = 0, no frame pulse.
- Asynchronous reset mid-frame: trigger drops on the reset edge; all counters clear.

Test Plan:
- Periodic, NUM_ADC=2, cfg_period=500; model controllers assert sampling 10 cycles after trigger for 200 cycles -> trigger rises every 500 cycles, high 4 cycles; frame_valid once per period; frame_index 1, 2, 3...; overrun_count stays 0.
- cfg_period=20 -> clamped: trigger spacing is exactly 100 cycles.
- Model busy for 800 cycles with P=500 -> every second tick dropped; overrun_count increments by 1 per frame; frame_valid every 1000 cycles.
- Controller B never asserts sampling -> frame_error 2500 cycles after trigger rise; timeout_count=1; no frame_valid; returns to ARMED and retriggers on the next tick.
- Software mode: three sw_trigger pulses, the second arriving during WAIT -> exactly 2 frames; overrun_count=0.
- adc_reset_down[1] held low at start -> trigger never asserts and active=0; after release, first trigger at P cycles. Drop cfg_enable mid-WAIT -> frame completes with frame_valid, then active=0.
